systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//   Downstream stage of the systolic matrix multiplier. Waits a fixed compute latency after a start
//   pulse, snapshots the multiplier's flat X*Y*M result bus, then streams it out one M-bit word per
//   handshake (valid/ready), with row/column tags. Frees the array for the next job once captured.
// PARAMETERS
//   M        8              result word width (bits)
//   X        4              number of filters (result rows)
//   Y        64             image data length (result columns)
//   L2       16             filter elements per dot product
//   DONE_CYC L2+X+Y-1 (=83) cycles from start to a valid result on Data
// PORTS
//   clk        in   1          clock, all logic on rising edge
//   rst        in   1          synchronous reset, active-low (rst==0 resets on clk edge)
//   start      in   1          1-cycle pulse, same cycle the multiplier job is launched
//   Data       in   X*Y*M      multiplier result bus; word k=x*Y+y at Data[k*M +: M]
//   out_ready  in   1          consumer ready
//   out_valid  out  1          out_data/out_row/out_col/out_last valid
//   out_data   out  M          result word
//   out_row    out  $clog2(X)  filter index x of current word
//   out_col    out  $clog2(Y)  image index y of current word
//   out_last   out  1          high with final word (x=X-1, y=Y-1)
//   busy       out  1          high in WAIT, CAPTURE, STREAM
//   captured   out  1          1-cycle pulse when snapshot taken (multiplier may restart)
//   done       out  1          1-cycle pulse after final word accepted
// BEHAVIOUR
//   Reset (rst==0 at edge): state=IDLE; all outputs 0; counters 0; snapshot register 0.
//   FSM: IDLE -> WAIT on start. WAIT: cycle counter 1..DONE_CYC; counter==DONE_CYC -> CAPTURE.
//     CAPTURE: snapshot<=Data, captured=1 for this cycle -> STREAM (index k=0).
//     STREAM: out_valid=1; transfer when out_valid&&out_ready; k increments per transfer.
//     Transfer with k==X*Y-1 -> IDLE, done=1 next cycle, out_valid=0.
//   Latency: first out_valid DONE_CYC+2 cycles after the start cycle.
//   Ordering: row-major, x outer, y inner; out_row=k/Y, out_col=k%Y (counters, no divider).
//   Data passes unmodified: out_data = snapshot[k*M +: M]; no sign/width change.
//   Stall: out_ready=0 holds out_data/out_row/out_col/out_last stable, k unchanged; valid never drops
//     until transfer (AXI-stream rule). out_valid must not depend combinationally on out_ready.
//   start while busy: ignored (no restart, no queue). start in same cycle as done: accepted -> WAIT.
//   Data changes after CAPTURE do not affect streamed words.
//   Reset mid-operation (any state): immediate IDLE, out_valid=0 next cycle, no done pulse.
//   Throughput: 1 word/cycle with out_ready held high; X*Y cycles in STREAM minimum.
// STRUCTURE
//   Shared package systolic_pkg: state enum {IDLE,WAIT,CAPTURE,STREAM}, localparams
//     WORDS=X*Y, ROW_W=$clog2(X), COL_W=$clog2(Y), CNT_W=$clog2(DONE_CYC+1).
//   One sub-module: drain_index_counter -- 2-D row/col counter with enable, last flag, sync clear.
//   Top holds FSM, latency counter, snapshot register, output mux.
// TESTING
//   1 Basic: start pulse, Data word k = k[7:0], out_ready=1 -> first valid at start+85, 256 words
//     0..255 in order, out_last only on word 255 (row 3, col 63), done 1 cycle later.
//   2 Backpressure: out_ready random 50% -> same 256-word sequence, outputs stable while stalled,
//     no drops/duplicates.
//   3 Snapshot: change Data to all 0xFF one cycle after captured -> streamed words still k[7:0].
//   4 Start while busy: second start pulse in WAIT and in STREAM -> ignored, single job of 256
//     words; start coincident with done -> new job begins, second first-valid 85 cycles later.
//   5 Reset mid-stream: rst=0 at word 100 -> out_valid=0, busy=0 next cycle, no done; new start
//     afterwards streams from word 0.
//   6 Small params X=2,Y=3,L2=4 -> DONE_CYC=8, 6 words, out_row/out_col 0/0,0/1,0/2,1/0,1/1,1/2.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic multiplier result drain.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } drain_state_e;

  localparam int M_DEF    = 8;
  localparam int X_DEF    = 4;
  localparam int Y_DEF    = 64;
  localparam int L2_DEF   = 16;
  localparam int DONE_CYC = L2_DEF + X_DEF + Y_DEF - 1;
  localparam int WORDS    = X_DEF * Y_DEF;
  localparam int ROW_W    = $clog2(X_DEF);
  localparam int COL_W    = $clog2(Y_DEF);
  localparam int CNT_W    = $clog2(DONE_CYC + 1);

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_index_counter.sv
// Row-major 2-D word index: column inner, row outer, with flat index and last-word flag.
module drain_index_counter
  import systolic_pkg::*;
#(
  parameter int ROWS = X_DEF,
  parameter int COLS = Y_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_i,
  input  logic                            en_i,
  output logic [width_of(ROWS)-1:0]       row_o,
  output logic [width_of(COLS)-1:0]       col_o,
  output logic [width_of(ROWS*COLS)-1:0]  idx_nxt_o,
  output logic                            last_o
);

  localparam int ROW_BITS = width_of(ROWS);
  localparam int COL_BITS = width_of(COLS);
  localparam int IDX_BITS = width_of(ROWS * COLS);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                last_q, last_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    idx_d = idx_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      if (col_q == COL_BITS'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_BITS'(ROWS - 1)) ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
        row_d = row_q;
      end
      idx_d = (idx_q == IDX_BITS'(ROWS * COLS - 1)) ? '0 : idx_q + IDX_BITS'(1);
    end else begin
      idx_d = idx_q;
    end
    last_d = (idx_d == IDX_BITS'(ROWS * COLS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q  <= '0;
      col_q  <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign idx_nxt_o = idx_d;
  assign last_o    = last_q;

endmodule

// File: rtl/systolic_result_drain.sv
// Waits out the multiplier latency, snapshots its result bus, then streams words over valid/ready.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int X  = X_DEF,
  parameter int Y  = Y_DEF,
  parameter int L2 = L2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [X*Y*M-1:0]        Data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [M-1:0]            out_data,
  output logic [width_of(X)-1:0]  out_row,
  output logic [width_of(Y)-1:0]  out_col,
  output logic                    out_last,
  output logic                    busy,
  output logic                    captured,
  output logic                    done
);

  localparam int LATENCY  = L2 + X + Y - 1;
  localparam int N_WORDS  = X * Y;
  localparam int IDX_BITS = width_of(N_WORDS);
  localparam int CNT_BITS = width_of(LATENCY + 1);

  drain_state_e        state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [M-1:0]        snap_q [N_WORDS];
  logic                out_valid_q;
  logic [M-1:0]        out_data_q;
  logic                busy_q;
  logic                captured_q;
  logic                done_q;

  logic                xfer;
  logic                clr_idx;
  logic [IDX_BITS-1:0] idx_nxt;
  logic                last_word;

  assign xfer    = (state_q == STREAM) && out_valid_q && out_ready;
  assign clr_idx = (state_q == CAPTURE);

  drain_index_counter #(
    .ROWS (X),
    .COLS (Y)
  ) u_index (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_idx),
    .en_i      (xfer),
    .row_o     (out_row),
    .col_o     (out_col),
    .idx_nxt_o (idx_nxt),
    .last_o    (last_word)
  );

  // Output data is pre-fetched from the next index so every output leaves a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      captured_q  <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      captured_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT;
            cnt_q   <= CNT_BITS'(1);
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_BITS'(LATENCY)) begin
            state_q    <= CAPTURE;
            captured_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        CAPTURE: begin
          for (int i = 0; i < N_WORDS; i++) begin
            snap_q[i] <= Data[i*M +: M];
          end
          out_data_q  <= Data[M-1:0];
          out_valid_q <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: begin
          if (xfer && last_word) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else if (xfer) begin
            out_data_q <= snap_q[idx_nxt];
          end else begin
            out_data_q <= out_data_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_valid_q & last_word;
  assign busy      = busy_q;
  assign captured  = captured_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: default geometry plus a small 2x3 instance.
module tb_systolic_result_drain;

  localparam int M     = 8;
  localparam int X     = 4;
  localparam int Y     = 64;
  localparam int WORDS = X * Y;
  localparam int XS    = 2;
  localparam int YS    = 3;
  localparam int WS    = XS * YS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, out_ready;
  logic [X*Y*M-1:0] data;
  logic             out_valid, out_last, busy, captured, done;
  logic [M-1:0]     out_data;
  logic [1:0]       out_row;
  logic [5:0]       out_col;

  logic               start_s;
  logic [XS*YS*M-1:0] data_s;
  logic               valid_s, last_s, busy_s, cap_s, done_s;
  logic [M-1:0]       odata_s;
  logic [0:0]         row_s;
  logic [1:0]         col_s;

  int n_checks = 0;
  int n_errors = 0;

  systolic_result_drain dut (
    .clk(clk), .rst(rst), .start(start), .Data(data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .captured(captured), .done(done)
  );

  systolic_result_drain #(.M(8), .X(XS), .Y(YS), .L2(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .Data(data_s), .out_ready(1'b1),
    .out_valid(valid_s), .out_data(odata_s), .out_row(row_s), .out_col(col_s),
    .out_last(last_s), .busy(busy_s), .captured(cap_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int k = 0; k < WORDS; k++) data[k*M +: M] = 8'(k);
  endtask

  // One job on the default instance; start is driven in the current cycle unless already high.
  task automatic run_job(input int ready_pct, input bit corrupt, input bit extra_start,
                         input bit start_at_done, input bit pre_started, input int abort_at);
    int cyc, k, guard, stray;
    bit rdy, cap_prev;
    if (!pre_started) start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    cap_prev = 1'b0;
    check("busy_in_wait", 32'(busy), 32'd1);
    while (!out_valid && cyc < 300) begin
      if (captured) check("captured_cycle", 32'(cyc), 32'd84);
      cap_prev = captured;
      start = extra_start && (cyc == 40);
      step();
      cyc++;
      if (corrupt && cap_prev) data = '1;
    end
    start = 1'b0;
    check("first_valid_cycle", 32'(cyc), 32'd85);
    k = 0;
    guard = 0;
    while (k < WORDS && guard < 3000) begin
      if (k == abort_at) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        stray = 0;
        for (int i = 0; i < 100; i++) begin
          step();
          if (done || out_valid || busy) stray++;
        end
        check("abort_quiet", 32'(stray), 32'd0);
        return;
      end
      check("valid_held", 32'(out_valid), 32'd1);
      check("data", 32'(out_data), 32'(k % 256));
      check("row", 32'(out_row), 32'(k / Y));
      check("col", 32'(out_col), 32'(k % Y));
      check("last", 32'(out_last), 32'(k == WORDS - 1));
      rdy = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      start = extra_start && (k == 10);
      step();
      guard++;
      if (rdy) k++;
    end
    start = start_at_done;
    check("words_streamed", 32'(k), 32'(WORDS));
    check("done_pulse", 32'(done), 32'd1);
    check("valid_after_done", 32'(out_valid), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    if (!start_at_done) begin
      step();
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int cyc, stray;
    rst = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    out_ready = 1'b1;
    fill_data();
    for (int k = 0; k < WS; k++) data_s[k*M +: M] = 8'(16 + k);
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_captured", 32'(captured), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_row_col", 32'({out_row, out_col}), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_small_valid", 32'(valid_s), 32'd0);
    rst = 1'b1;
    step();

    run_job(100, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_job(50, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    out_ready = 1'b1;
    run_job(100, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    fill_data();

    run_job(100, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_valid || busy) stray++;
    end
    check("ignored_start_idle", 32'(stray), 32'd0);

    run_job(100, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    run_job(100, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    run_job(100, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    run_job(100, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    start_s = 1'b1;
    step();
    start_s = 1'b0;
    cyc = 1;
    while (!valid_s && cyc < 50) begin
      step();
      cyc++;
    end
    check("s_first_valid_cycle", 32'(cyc), 32'd10);
    for (int k = 0; k < WS; k++) begin
      check("s_valid", 32'(valid_s), 32'd1);
      check("s_data", 32'(odata_s), 32'(16 + k));
      check("s_row", 32'(row_s), 32'(k / YS));
      check("s_col", 32'(col_s), 32'(k % YS));
      check("s_last", 32'(last_s), 32'(k == WS - 1));
      step();
    end
    check("s_done", 32'(done_s), 32'd1);
    check("s_valid_after_done", 32'(valid_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
